// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, branch squash, decoder handshake.
// Optional build macro FETCH_NOOP_FILL_EN: inst_out reads 8'h00 whenever inst_valid_out is low.
module fetch_unit #(
   parameter int unsigned           ADDR_W   = 32'd8,
   parameter logic [ADDR_W-1:0]     RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk_in,
   input  logic              reset_in,
   output logic              imem_req_out,
   output logic [ADDR_W-1:0] imem_addr_out,
   input  logic              imem_valid_in,
   input  logic [7:0]        imem_data_in,
   output logic [7:0]        inst_out,
   output logic              inst_valid_out,
   output logic [ADDR_W-1:0] inst_pc_out,
   input  logic              stall_in,
   input  logic              branch_taken_in,
   input  logic [ADDR_W-1:0] branch_target_in
);

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_next_s;
   logic              squash_r;
   logic              squash_next_s;
   logic              capture_s;
   logic              release_s;
   logic              req_s;
   logic [7:0]        inst_r;
   logic              inst_valid_r;
   logic [ADDR_W-1:0] inst_pc_r;

   // FSM state, PC and squash flag
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_r  <= ST_ISSUE;
         pc_r     <= RESET_PC;
         // a request still in flight must have its late response discarded
         squash_r <= (state_r == ST_WAIT);
      end else begin
         state_r  <= state_next_s;
         pc_r     <= pc_next_s;
         squash_r <= squash_next_s;
      end
   end

   // Next-state, PC and handshake decode; branch outranks every non-reset event
   always_comb begin
      state_next_s  = state_r;
      pc_next_s     = pc_r;
      squash_next_s = squash_r;
      capture_s     = 1'b0;
      release_s     = 1'b0;
      req_s         = 1'b0;
      case (state_r)
         ST_ISSUE: begin
            req_s        = 1'b1;
            state_next_s = ST_WAIT;
            if (branch_taken_in) begin
               pc_next_s     = branch_target_in;
               squash_next_s = 1'b1;
            end else begin
               squash_next_s = squash_r;
            end
         end
         ST_WAIT: begin
            if (branch_taken_in) begin
               pc_next_s = branch_target_in;
               if (imem_valid_in) begin
                  squash_next_s = 1'b0;
                  state_next_s  = ST_ISSUE;
               end else begin
                  squash_next_s = 1'b1;
               end
            end else if (imem_valid_in) begin
               squash_next_s = 1'b0;
               state_next_s  = ST_ISSUE;
               if (!squash_r) begin
                  capture_s    = 1'b1;
                  pc_next_s    = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  state_next_s = ST_HOLD;
               end else begin
                  capture_s = 1'b0;
               end
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (branch_taken_in) begin
               pc_next_s    = branch_target_in;
               release_s    = 1'b1;
               state_next_s = ST_ISSUE;
            end else if (!stall_in) begin
               release_s    = 1'b1;
               state_next_s = ST_ISSUE;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            state_next_s  = ST_ISSUE;
            squash_next_s = 1'b0;
         end
      endcase
   end

   // Instruction output register towards the decoder
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         inst_r       <= 8'h00;
         inst_valid_r <= 1'b0;
         inst_pc_r    <= {ADDR_W{1'b0}};
      end else if (capture_s) begin
         inst_r       <= imem_data_in;
         inst_valid_r <= 1'b1;
         inst_pc_r    <= pc_r;
      end else if (release_s) begin
         inst_valid_r <= 1'b0;
`ifdef FETCH_NOOP_FILL_EN
         inst_r       <= 8'h00;
`else
         inst_r       <= inst_r;
`endif
      end else begin
         inst_valid_r <= inst_valid_r;
      end
   end

   assign imem_req_out   = req_s & ~reset_in;
   assign imem_addr_out  = pc_r;
   assign inst_out       = inst_r;
   assign inst_valid_out = inst_valid_r;
   assign inst_pc_out    = inst_pc_r;

   fetch_unit_chk u_chk (
      .clk_in        (clk_in),
      .reset_in      (reset_in),
      .in_wait       (state_r == ST_WAIT),
      .imem_valid_in (imem_valid_in)
   );

endmodule

// Protocol checker: memory may only answer while the fetch unit is waiting.
module fetch_unit_chk (
   input logic clk_in,
   input logic reset_in,
   input logic in_wait,
   input logic imem_valid_in
);

   valid_only_in_wait_a : assert property (
      @(posedge clk_in) disable iff (reset_in) imem_valid_in |-> in_wait
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: variable-latency memory model, scoreboard and vector table.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       reset_in = 1'b1;
   logic       imem_req_out;
   logic [7:0] imem_addr_out;
   logic       imem_valid_in = 1'b0;
   logic [7:0] imem_data_in = 8'h00;
   logic [7:0] inst_out;
   logic       inst_valid_out;
   logic [7:0] inst_pc_out;
   logic       stall_in = 1'b0;
   logic       branch_taken_in = 1'b0;
   logic [7:0] branch_target_in = 8'h00;

   int tests = 0;
   int fails = 0;

   logic [7:0]  mem [256];
   int          mem_lat = 1;
   int          cnt = 0;
   logic        expect_drop = 1'b0;
   logic [15:0] exp_q [$];

`ifdef FETCH_NOOP_FILL_EN
   localparam logic [7:0] IDLE_INST = 8'h00;
`else
   localparam logic [7:0] IDLE_INST = 8'h1A;
`endif

   typedef struct {
      int         lat;
      int         stall;
      logic [7:0] exp_inst;
      logic [7:0] exp_pc;
   } vec_t;
   vec_t vecs [4];

   fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk_in           (clk),
      .reset_in         (reset_in),
      .imem_req_out     (imem_req_out),
      .imem_addr_out    (imem_addr_out),
      .imem_valid_in    (imem_valid_in),
      .imem_data_in     (imem_data_in),
      .inst_out         (inst_out),
      .inst_valid_out   (inst_valid_out),
      .inst_pc_out      (inst_pc_out),
      .stall_in         (stall_in),
      .branch_taken_in  (branch_taken_in),
      .branch_target_in (branch_target_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      for (int w = 0; w < 20 && !inst_valid_out; w++) step();
      chk({name, "_timeout"}, 32'(inst_valid_out), 32'd1);
   endtask

   task automatic wait_req(input string name);
      logic seen_valid;
      seen_valid = 1'b0;
      for (int w = 0; w < 20 && !imem_req_out; w++) begin
         step();
         if (inst_valid_out) seen_valid = 1'b1;
      end
      chk({name, "_timeout"}, 32'(imem_req_out), 32'd1);
      chk({name, "_no_valid"}, 32'(seen_valid), 32'd0);
   endtask

   // Memory model: one response per request after mem_lat cycles; expectation queued on response
   initial begin
      logic       rs;
      logic [7:0] ra;
      logic [7:0] pa;
      pa = 8'h00;
      forever begin
         @(negedge clk);
         rs = imem_req_out;
         ra = imem_addr_out;
         @(posedge clk);
         #1;
         imem_valid_in = 1'b0;
         if (rs) begin
            cnt = mem_lat;
            pa  = ra;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               imem_valid_in = 1'b1;
               imem_data_in  = mem[pa];
               if (expect_drop) expect_drop = 1'b0;
               else exp_q.push_back({mem[pa], pa});
            end
         end
      end
   end

   // Scoreboard: every new valid instruction must match the oldest expected response
   initial begin
      logic        prev_v;
      logic [15:0] e;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (inst_valid_out && !prev_v) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_inst", 32'(inst_out), 32'(e[15:8]));
               chk("sb_pc", 32'(inst_pc_out), 32'(e[7:0]));
            end
         end
         prev_v = inst_valid_out;
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
      mem[0] = 8'h1A; mem[1] = 8'h2B; mem[2] = 8'h3C; mem[3] = 8'h4D; mem[4] = 8'h5E;
      vecs[0] = '{lat: 1, stall: 0, exp_inst: 8'h2B, exp_pc: 8'h01};
      vecs[1] = '{lat: 2, stall: 4, exp_inst: 8'h3C, exp_pc: 8'h02};
      vecs[2] = '{lat: 3, stall: 1, exp_inst: 8'h4D, exp_pc: 8'h03};
      vecs[3] = '{lat: 1, stall: 2, exp_inst: 8'h5E, exp_pc: 8'h04};

      // reset state
      step();
      chk("rst_req", 32'(imem_req_out), 32'd0);
      chk("rst_valid", 32'(inst_valid_out), 32'd0);
      chk("rst_inst", 32'(inst_out), 32'h00);
      chk("rst_pc", 32'(inst_pc_out), 32'h00);
      step();
      reset_in = 1'b0;
      #1;
      // first fetch, cycle exact: ISSUE, WAIT, HOLD, ISSUE
      chk("c1_req", 32'(imem_req_out), 32'd1);
      chk("c1_addr", 32'(imem_addr_out), 32'h00);
      step();
      chk("c2_req", 32'(imem_req_out), 32'd0);
      step();
      chk("c3_valid", 32'(inst_valid_out), 32'd1);
      chk("c3_inst", 32'(inst_out), 32'h1A);
      chk("c3_pc", 32'(inst_pc_out), 32'h00);
      step();
      chk("c4_req", 32'(imem_req_out), 32'd1);
      chk("c4_addr", 32'(imem_addr_out), 32'h01);
      chk("c4_valid", 32'(inst_valid_out), 32'd0);
      chk("idle_inst_issue", 32'(inst_out), 32'(IDLE_INST));
      step();
      chk("idle_inst_wait", 32'(inst_out), 32'(IDLE_INST));

      // straight-line fetches with varying latency and stall length
      for (int v = 0; v < 4; v++) begin
         mem_lat  = vecs[v].lat;
         stall_in = (vecs[v].stall > 0);
         wait_valid($sformatf("vec%0d", v));
         chk($sformatf("vec%0d_inst", v), 32'(inst_out), 32'(vecs[v].exp_inst));
         chk($sformatf("vec%0d_pc", v), 32'(inst_pc_out), 32'(vecs[v].exp_pc));
         for (int k = 0; k < vecs[v].stall; k++) begin
            step();
            chk($sformatf("vec%0d_stall_valid", v), 32'(inst_valid_out), 32'd1);
            chk($sformatf("vec%0d_stall_inst", v), 32'(inst_out), 32'(vecs[v].exp_inst));
            chk($sformatf("vec%0d_stall_pc", v), 32'(inst_pc_out), 32'(vecs[v].exp_pc));
            chk($sformatf("vec%0d_stall_req", v), 32'(imem_req_out), 32'd0);
         end
         stall_in = 1'b0;
         step();
      end

      // branch in WAIT with 3-cycle memory: response dropped, refetch at 0x40
      chk("bw_addr_old", 32'(imem_addr_out), 32'h05);
      mem_lat = 3;
      step();
      expect_drop = 1'b1;
      branch_taken_in = 1'b1;
      branch_target_in = 8'h40;
      step();
      branch_taken_in = 1'b0;
      wait_req("bw_req");
      chk("bw_addr", 32'(imem_addr_out), 32'h40);
      mem_lat = 1;
      wait_valid("bw_fetch");
      chk("bw_inst", 32'(inst_out), 32'hE5);

      // branch in HOLD while stalled: held instruction dropped
      stall_in = 1'b1;
      branch_taken_in = 1'b1;
      branch_target_in = 8'h80;
      step();
      branch_taken_in = 1'b0;
      stall_in = 1'b0;
      chk("bh_valid", 32'(inst_valid_out), 32'd0);
      chk("bh_req", 32'(imem_req_out), 32'd1);
      chk("bh_addr", 32'(imem_addr_out), 32'h80);
      wait_valid("bh_fetch");
      chk("bh_inst", 32'(inst_out), 32'h25);
      step();

      // branch in ISSUE: old request still issued, its response squashed
      chk("bi_addr_old", 32'(imem_addr_out), 32'h81);
      expect_drop = 1'b1;
      branch_taken_in = 1'b1;
      branch_target_in = 8'hFF;
      step();
      branch_taken_in = 1'b0;
      wait_req("bi_req");
      chk("bi_addr", 32'(imem_addr_out), 32'hFF);

      // fetch at 0xFF wraps the PC
      wait_valid("wrap_fetch");
      chk("wrap_pc", 32'(inst_pc_out), 32'hFF);
      chk("wrap_inst", 32'(inst_out), 32'h5A);
      step();
      chk("wrap_next_addr", 32'(imem_addr_out), 32'h00);

      // reset mid-operation while holding an instruction
      wait_valid("mr_fetch");
      stall_in = 1'b1;
      reset_in = 1'b1;
      step();
      chk("mr_valid", 32'(inst_valid_out), 32'd0);
      chk("mr_inst", 32'(inst_out), 32'h00);
      chk("mr_req", 32'(imem_req_out), 32'd0);
      reset_in = 1'b0;
      stall_in = 1'b0;
      #1;
      chk("mr_addr", 32'(imem_addr_out), 32'h00);
      wait_valid("mr_refetch");
      chk("mr_re_inst", 32'(inst_out), 32'h1A);
      step();
      step();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      chk("drop_consumed", 32'(expect_drop), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
